noc_ring_injector: RTL and testbench
====================================

// Module: noc_ring_injector
//
// PURPOSE
// Local-port packet source of a ring NoC router; the transmit end of the router's per-hop routing.
// Accepts a command (destination, body length) and a payload word stream.
// Emits a header flit carrying the first-hop direction (goEast/goWest/goLocal), then body flits.
// Downstream routers derive later hops from the header's destination.
//
// PARAMETERS
// DataWidth   32  flit payload width; must be >= header field total (see BEHAVIOUR)
// MaxBody     15  max body flits per packet
// LenWidth    4   width of length field; $clog2(MaxBody+1)
//
// PORTS
// clk          in   1           clock; single clock domain
// rst          in   1           synchronous reset, active-high
// position     in   xy_t        static router coordinate; sampled into a register every cycle
// req_valid    in   1           command valid
// req_ready    out  1           command accepted when valid&ready
// req_dest     in   xy_t        destination coordinate
// req_len      in   LenWidth    body flit count, 0..MaxBody
// in_valid     in   1           payload word valid
// in_ready     out  1           payload word accepted when valid&ready
// in_data      in   DataWidth   payload word
// flit_valid   out  1           flit to router valid
// flit_ready   in   1           router accepts flit
// flit_data    out  DataWidth   flit payload
// flit_type    out  flit_type_t kHead/kBody/kTail/kHeadTail
// flit_route   out  direction_t one-hot first-hop direction; valid on header flits, 0 otherwise
//
// BEHAVIOUR
// - Reset: state=INIT; req_ready=0, in_ready=0, flit_valid=0, flit_route=0, flit_type=kHead, flit_data=0.
// - pos_q <= position every cycle, not reset. INIT lasts exactly 1 cycle after rst deasserts, then IDLE.
// - IDLE: req_ready=1. On req_valid:
//   - latch dest and len;
//   - compute route from pos_q;
//   - go to HEAD.
//   - req_len>MaxBody is clamped to MaxBody.
// - Route calc, kRingSize from package, all arithmetic mod kRingSize in int:
//   - cw=(dest.x-pos.x+kRingSize)%kRingSize; ccw=(pos.x-dest.x+kRingSize)%kRingSize;
//   - cw==0 -> goLocal; cw<=ccw -> goEast (tie goes East); else goWest.
// - HEAD: flit_valid=1.
//   - flit_data = {zero pad, len, src=pos_q at accept, dest}, dest in LSBs.
//   - flit_type = kHeadTail if len==0, else kHead.
//   - On flit_ready: len==0 -> IDLE, else BODY with cnt=len.
// - BODY: pass-through, zero added latency.
//   - flit_valid=in_valid; in_ready=flit_ready; flit_data=in_data.
//   - flit_type = kTail when cnt==1, else kBody; flit_route=0.
//   - cnt decrements on each transfer. Tail transfer -> IDLE.
// - Latency: command accepted at cycle t -> header valid at t+1. Minimum gap is 1 idle cycle between packets.
// - Handshake: once flit_valid=1 in HEAD, flit_data, flit_type and flit_route hold stable until flit_ready.
//   In BODY, stability follows the upstream in_valid/in_data contract.
// - req_ready=0 outside IDLE. in_ready=0 outside BODY; payload presented early is never consumed.
// - position changes mid-packet do not affect a latched header.
// - Reset mid-packet: the partial packet is dropped. Outputs take reset values the next cycle.
//   No tail is emitted; the router clears on the same reset.
//
// STRUCTURE
// - Package noc adds:
//   - flit_type_t enum;
//   - header_t packed struct {len, src xy_t, dest xy_t};
//   - function ring_route(xy_t from, xy_t dest) returning direction_t.
//   Existing xy_t, direction_t, goEast/goWest/goLocal and kRingSize are reused.
// - Sub-module noc_ring_route_calc: registered wrapper computing the route at command accept.
// - FSM enum {INIT, IDLE, HEAD, BODY}. One LenWidth down-counter.
//
// TESTING (kRingSize=8)
// - pos.x=2, dest.x=5, len=3, ready=1 -> kHead route goEast; kBody, kBody, kTail; data order preserved.
// - pos.x=2, dest.x=7 -> goWest (cw=5, ccw=3). pos.x=0, dest.x=4 -> goEast (tie).
//   pos.x=6, dest.x=1 -> goEast (wrap, cw=3).
// - dest.x==pos.x, len=0 -> single kHeadTail flit, route goLocal; req_ready=1 again 1 cycle after transfer.
// - flit_ready low 3 cycles during HEAD -> header fields bit-stable; in_ready=0 throughout.
// - in_valid gaps in BODY -> flit_valid tracks in_valid; cnt unchanged on idle cycles.
// - rst pulse after 2 of 5 body flits -> next cycle flit_valid=0;
//   INIT then IDLE; next packet starts with a fresh header.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared ring NoC types, injector header layout and first-hop routing helper.
package noc_pkg;

    localparam int kRingSize   = 8;
    localparam int kCoordWidth = 3;
    localparam int kLenWidth   = 4;

    typedef struct packed {
        logic [kCoordWidth-1:0] y;
        logic [kCoordWidth-1:0] x;
    } xy_t;

    // One-hot first-hop direction; all-zero means "no route" on non-header flits.
    typedef logic [2:0] direction_t;
    localparam direction_t goEast  = 3'b001;
    localparam direction_t goWest  = 3'b010;
    localparam direction_t goLocal = 3'b100;

    typedef enum logic [1:0] {kHead, kBody, kTail, kHeadTail} flit_type_t;

    typedef struct packed {
        logic [kLenWidth-1:0] len;
        xy_t                  src;
        xy_t                  dest;
    } header_t;

    // Shortest way round the ring on the x axis; equal distances go East.
    function automatic direction_t ring_route(xy_t from, xy_t dest);
        int cw;
        int ccw;
        cw  = (int'(dest.x) - int'(from.x) + kRingSize) % kRingSize;
        ccw = (int'(from.x) - int'(dest.x) + kRingSize) % kRingSize;
        return (cw == 0) ? goLocal : (cw <= ccw) ? goEast : goWest;
    endfunction

endpackage

// File: rtl/noc_ring_injector_route_calc.sv
// noc_ring_route_calc: registers the first-hop direction when a command is accepted.
module noc_ring_route_calc
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  xy_t        from,
    input  xy_t        dest,
    output direction_t route
);

    always_ff @(posedge clk) begin
        if (rst)
            route <= '0;
        else if (load)
            route <= ring_route(from, dest);
    end

endmodule

// File: rtl/noc_ring_injector.sv
// noc_ring_injector: local-port packet source; emits a routed header flit then
// passes the payload stream straight through as body flits.
module noc_ring_injector
    import noc_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int MaxBody   = 15,
    parameter int LenWidth  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  xy_t                  position,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  xy_t                  req_dest,
    input  logic [LenWidth-1:0]  req_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_data,
    output logic                 flit_valid,
    input  logic                 flit_ready,
    output logic [DataWidth-1:0] flit_data,
    output flit_type_t           flit_type,
    output direction_t           flit_route
);

    typedef enum logic [1:0] {INIT, IDLE, HEAD, BODY} state_t;

    state_t              state;
    state_t              state_d;
    xy_t                 pos_q;
    header_t             hdr;
    direction_t          route_q;
    logic [LenWidth-1:0] cnt;
    logic [LenWidth-1:0] len_c;
    logic                accept;
    logic                body_xfer;

    assign len_c     = (req_len > LenWidth'(MaxBody)) ? LenWidth'(MaxBody) : req_len;
    assign accept    = (state == IDLE) && req_valid;
    assign body_xfer = (state == BODY) && in_valid && flit_ready;

    noc_ring_route_calc u_route (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .from (pos_q),
        .dest (req_dest),
        .route(route_q)
    );

    // Coordinate is static in practice, so it is simply re-sampled and never reset.
    always_ff @(posedge clk)
        pos_q <= position;

    always_ff @(posedge clk) begin
        state <= rst ? INIT : state_d;
        if (accept)
            hdr <= '{len: kLenWidth'(len_c), src: pos_q, dest: req_dest};
        if (state == HEAD && flit_ready)
            cnt <= LenWidth'(hdr.len);
        else if (body_xfer)
            cnt <= cnt - LenWidth'(1);
    end

    always_comb begin
        state_d = state;
        unique case (state)
            INIT:    state_d = IDLE;
            IDLE:    if (req_valid) state_d = HEAD;
            HEAD:    if (flit_ready) state_d = (hdr.len == '0) ? IDLE : BODY;
            BODY:    if (body_xfer && cnt == LenWidth'(1)) state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    // Body flits are a zero-latency pass-through of the payload handshake.
    always_comb begin
        req_ready  = state == IDLE;
        in_ready   = (state == BODY) && flit_ready;
        flit_valid = (state == HEAD) || ((state == BODY) && in_valid);
        flit_data  = (state == HEAD) ? DataWidth'(hdr) : (state == BODY) ? in_data : '0;
        flit_type  = (state == HEAD) ? ((hdr.len == '0) ? kHeadTail : kHead) :
                     (state == BODY) ? ((cnt == LenWidth'(1)) ? kTail : kBody) : kHead;
        flit_route = (state == HEAD) ? route_q : '0;
    end

endmodule

// File: tb/tb_noc_ring_injector.sv
// tb_noc_ring_injector: randomized scenarios against a packet-level reference model.
module tb_noc_ring_injector;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    xy_t         position;
    logic        req_valid;
    logic        req_ready;
    xy_t         req_dest;
    logic [3:0]  req_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        flit_valid;
    logic        flit_ready;
    logic [31:0] flit_data;
    flit_type_t  flit_type;
    direction_t  flit_route;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    noc_ring_injector dut (
        .clk       (clk),
        .rst       (rst),
        .position  (position),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dest  (req_dest),
        .req_len   (req_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flit_valid(flit_valid),
        .flit_ready(flit_ready),
        .flit_data (flit_data),
        .flit_type (flit_type),
        .flit_route(flit_route)
    );

    // Walk the ring eastward to count hops; the westward distance is the remainder.
    function automatic direction_t ref_route(int p, int d);
        int east;
        int x;
        if (p == d) return goLocal;
        east = 0;
        x = p;
        while (x != d) begin
            x = (x + 1) % 8;
            east++;
        end
        return (east <= 8 - east) ? goEast : goWest;
    endfunction

    // Packet-level model: header then len payload words, with optional stalls and gaps.
    task automatic run_pkt(input int px, input int py, input int dx, input int dy,
                           input int len, input int head_stall, input bit gaps, input string tag);
        logic [31:0] words[$];
        logic [31:0] exp_hdr;
        logic [39:0] got;
        logic [39:0] exp;
        flit_type_t  exp_ty;
        int          idx;
        int          budget;
        req_valid  = 1'b0;
        in_valid   = 1'b0;
        flit_ready = 1'b0;
        position   = {3'(py), 3'(px)};
        repeat (2) @(negedge clk);
        for (int i = 0; i < len; i++) words.push_back($urandom);
        exp_hdr = (32'(len) << 12) | (32'(py * 8 + px) << 6) | 32'(dy * 8 + dx);
        exp_ty  = (len == 0) ? kHeadTail : kHead;
        req_valid = 1'b1;
        req_dest  = {3'(dy), 3'(dx)};
        req_len   = 4'(len);
        in_valid  = 1'b1;
        in_data   = $urandom;
        #1;
        compared++;
        if ({req_ready, in_ready, flit_valid} !== 3'b100) begin
            mismatched++;
            $display("FAIL %s idle: got rdy/in_rdy/fv=%b want 100", tag, {req_ready, in_ready, flit_valid});
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_dest  = xy_t'($urandom);
        req_len   = 4'($urandom);
        position  = xy_t'($urandom);
        for (int s = 0; s <= head_stall; s++) begin
            flit_ready = (s == head_stall);
            #1;
            got = {flit_valid, flit_data, flit_type, flit_route, in_ready, req_ready};
            exp = {1'b1, exp_hdr, exp_ty, ref_route(px, dx), 1'b0, 1'b0};
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL %s head cyc%0d: got %h want %h", tag, s, got, exp);
            end
            @(negedge clk);
        end
        idx = 0;
        budget = 0;
        while (idx < len && budget < 300) begin
            in_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            flit_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data    = words[idx];
            #1;
            got = {flit_valid, flit_data, flit_type, flit_route, in_ready, req_ready};
            exp = {in_valid, in_data, (idx == len - 1) ? kTail : kBody, 3'b000, flit_ready, 1'b0};
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL %s body%0d: got %h want %h", tag, idx, got, exp);
            end
            if (in_valid && flit_ready) idx++;
            budget++;
            @(negedge clk);
        end
        if (budget >= 300) begin
            compared++;
            mismatched++;
            $display("FAIL %s body timeout: got %0d flits want %0d", tag, idx, len);
        end
        in_valid   = 1'b0;
        flit_ready = 1'b0;
        #1;
        compared++;
        if ({req_ready, flit_valid} !== 2'b10) begin
            mismatched++;
            $display("FAIL %s back to idle: got rdy/fv=%b want 10", tag, {req_ready, flit_valid});
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 1'b0;
        in_valid   = 1'b0;
        flit_ready = 1'b0;
        req_dest   = '0;
        req_len    = '0;
        in_data    = '0;
        position   = '0;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if ({req_ready, in_ready, flit_valid, flit_data, flit_type, flit_route} !== {3'b000, 32'h0, kHead, 3'b000}) begin
            mismatched++;
            $display("FAIL reset outputs: got %b %b %b %h %0d %b", req_ready, in_ready, flit_valid, flit_data, flit_type, flit_route);
        end
        rst = 1'b0;
        #1;
        compared++;
        if (req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset init cycle: got req_ready=%b want 0", req_ready);
        end
        @(negedge clk);
        #1;
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset to idle: got req_ready=%b want 1", req_ready);
        end
    endtask

    task automatic test_routes();
        run_pkt(2, 1, 5, 3, 3, 0, 1'b0, "east");
        run_pkt(2, 0, 7, 2, 2, 0, 1'b0, "west");
        run_pkt(0, 4, 4, 1, 1, 0, 1'b0, "tie");
        run_pkt(6, 2, 1, 5, 2, 0, 1'b0, "wrap");
        run_pkt(3, 3, 3, 6, 0, 0, 1'b0, "local_len0");
        run_pkt(5, 7, 5, 0, 15, 0, 1'b0, "max_len");
    endtask

    task automatic test_head_stall();
        run_pkt(1, 2, 4, 3, 2, 3, 1'b0, "head_stall");
        run_pkt(7, 0, 0, 0, 0, 3, 1'b0, "head_stall_len0");
    endtask

    task automatic test_body_gaps();
        run_pkt(4, 5, 1, 1, 6, 1, 1'b1, "body_gaps");
    endtask

    task automatic test_reset_mid_packet();
        position   = {3'd1, 3'd2};
        repeat (2) @(negedge clk);
        req_valid  = 1'b1;
        req_dest   = {3'd0, 3'd6};
        req_len    = 4'd5;
        @(negedge clk);
        req_valid  = 1'b0;
        flit_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        repeat (2) begin
            in_data = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        #1;
        compared++;
        if ({flit_valid, req_ready, in_ready, flit_route} !== 6'b0) begin
            mismatched++;
            $display("FAIL midrst outputs: got fv=%b rdy=%b in_rdy=%b rt=%b want 0", flit_valid, req_ready, in_ready, flit_route);
        end
        rst = 1'b0;
        #1;
        compared++;
        if (req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst init: got req_ready=%b want 0", req_ready);
        end
        @(negedge clk);
        #1;
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL midrst idle: got req_ready=%b want 1", req_ready);
        end
        run_pkt(2, 1, 5, 1, 3, 0, 1'b0, "after_rst");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++)
            run_pkt($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 15), $urandom_range(0, 2), 1'($urandom_range(0, 1)), "random");
    endtask

    initial begin
        test_reset();
        test_routes();
        test_head_stall();
        test_body_gaps();
        test_reset_mid_packet();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
